// File: rtl/retire_unit_pkg.sv
// Shared types for the retire stage: ROB head entry layout and retire FSM states.
package retire_unit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        exc_valid;
        logic [4:0]  exc_code;
        logic        is_store;
        logic        dest_reg_valid;
        logic [4:0]  dest_reg;
        logic [31:0] result_lo;
    } rob_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } retire_state_t;

endpackage

// File: rtl/retire_unit_window.sv
// Combinational retire-window finder: longest in-order prefix of valid, non-faulting
// slots holding at most one store (and only when the store buffer can take it).
module retire_unit_window
    import retire_unit_pkg::*;
#(
    parameter int RETIRE_COUNT = 4,
    parameter int IDX_WIDTH    = $clog2(RETIRE_COUNT),
    parameter int N_WIDTH      = $clog2(RETIRE_COUNT + 1)
) (
    input  rob_entry_t [RETIRE_COUNT-1:0] slot_data_i,
    input  logic [RETIRE_COUNT-1:0]       slot_valid_i,
    input  logic                          store_ready_i,
    output logic [N_WIDTH-1:0]            n_o,
    output logic [RETIRE_COUNT-1:0]       retire_mask_o,
    output logic                          store_in_win_o,
    output logic                          fault_o,
    output logic [IDX_WIDTH-1:0]          fault_idx_o
);

    logic stop;

    always_comb begin
        n_o            = '0;
        retire_mask_o  = '0;
        store_in_win_o = 1'b0;
        fault_o        = 1'b0;
        fault_idx_o    = '0;
        stop           = 1'b0;
        for (int i = 0; i < RETIRE_COUNT; i++) begin
            if (!stop) begin
                if (!slot_valid_i[i]) begin
                    stop = 1'b1;
                end else if (slot_data_i[i].exc_valid) begin
                    // The first slot past the window is the one that faults.
                    stop        = 1'b1;
                    fault_o     = 1'b1;
                    fault_idx_o = IDX_WIDTH'(i);
                end else if (slot_data_i[i].is_store && (store_in_win_o || !store_ready_i)) begin
                    stop = 1'b1;
                end else begin
                    retire_mask_o[i] = 1'b1;
                    n_o              = N_WIDTH'(i + 1);
                    if (slot_data_i[i].is_store) begin
                        store_in_win_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/retire_unit.sv
// In-order retirement of up to RETIRE_COUNT ROB head entries per cycle, with
// exception flush/drain sequencing, registered register-file writes and a retire counter.
module retire_unit
    import retire_unit_pkg::*;
#(
    parameter int RETIRE_COUNT = 4,
    parameter int COUNT_WIDTH  = $clog2(RETIRE_COUNT),
    parameter int CNT_WIDTH    = 32
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  rob_entry_t [RETIRE_COUNT-1:0]      slot_data_i,
    input  logic [RETIRE_COUNT-1:0]            slot_valid_i,
    input  logic                               empty_i,
    output logic                               consume_o,
    output logic [COUNT_WIDTH-1:0]             consume_count_o,
    input  logic                               store_ready_i,
    output logic                               store_commit_o,
    output logic                               flush_o,
    output logic [31:0]                        exc_pc_o,
    output logic [4:0]                         exc_code_o,
    output logic [RETIRE_COUNT-1:0][4:0]       rfile_wr_addr_o,
    output logic [RETIRE_COUNT-1:0]            rfile_wr_enable_o,
    output logic [RETIRE_COUNT-1:0][31:0]      rfile_wr_data_o,
    output logic [CNT_WIDTH-1:0]               retired_count_o
);

    localparam int N_WIDTH = $clog2(RETIRE_COUNT + 1);

    retire_state_t                       state_q, state_d;
    logic [N_WIDTH-1:0]                  win_n;
    logic [RETIRE_COUNT-1:0]             win_mask;
    logic                                win_store;
    logic                                win_fault;
    logic [COUNT_WIDTH-1:0]              win_fault_idx;
    logic                                run;
    logic                                take_fault;
    logic [N_WIDTH-1:0]                  n_eff;
    logic [RETIRE_COUNT-1:0]             retire_eff;
    logic [RETIRE_COUNT-1:0][RETIRE_COUNT-1:0] younger_match;
    logic [RETIRE_COUNT-1:0]             wr_en_d;

    logic                                flush_q;
    logic [31:0]                         exc_pc_q, exc_pc_d;
    logic [4:0]                          exc_code_q, exc_code_d;
    logic [RETIRE_COUNT-1:0][4:0]        wr_addr_q;
    logic [RETIRE_COUNT-1:0]             wr_en_q;
    logic [RETIRE_COUNT-1:0][31:0]       wr_data_q;
    logic [CNT_WIDTH-1:0]                retired_q, retired_d;

    retire_unit_window #(
        .RETIRE_COUNT (RETIRE_COUNT),
        .IDX_WIDTH    (COUNT_WIDTH),
        .N_WIDTH      (N_WIDTH)
    ) u_window (
        .slot_data_i    (slot_data_i),
        .slot_valid_i   (slot_valid_i),
        .store_ready_i  (store_ready_i),
        .n_o            (win_n),
        .retire_mask_o  (win_mask),
        .store_in_win_o (win_store),
        .fault_o        (win_fault),
        .fault_idx_o    (win_fault_idx)
    );

    assign run             = (state_q == RUN);
    assign take_fault      = run && win_fault;
    assign n_eff           = run ? win_n : '0;
    assign retire_eff      = run ? win_mask : '0;
    assign consume_o       = (n_eff != '0);
    assign consume_count_o = consume_o ? COUNT_WIDTH'(n_eff - N_WIDTH'(1)) : '0;
    assign store_commit_o  = run && win_store;

    // A slot writes only if no younger retiring slot targets the same register.
    for (genvar gi = 0; gi < RETIRE_COUNT; gi++) begin : g_wr
        for (genvar gj = 0; gj < RETIRE_COUNT; gj++) begin : g_cmp
            if (gj > gi) begin : g_younger
                assign younger_match[gi][gj] = retire_eff[gj] && slot_data_i[gj].dest_reg_valid
                                               && (slot_data_i[gj].dest_reg == slot_data_i[gi].dest_reg);
            end else begin : g_older
                assign younger_match[gi][gj] = 1'b0;
            end
        end
        assign wr_en_d[gi] = retire_eff[gi] && slot_data_i[gi].dest_reg_valid
                             && (slot_data_i[gi].dest_reg != 5'd0) && !(|younger_match[gi]);
    end

    always_comb begin
        state_d    = state_q;
        exc_pc_d   = exc_pc_q;
        exc_code_d = exc_code_q;
        retired_d  = retired_q + CNT_WIDTH'(n_eff);
        case (state_q)
            RUN: begin
                if (take_fault) begin
                    state_d    = FLUSH;
                    exc_pc_d   = slot_data_i[win_fault_idx].pc;
                    exc_code_d = slot_data_i[win_fault_idx].exc_code;
                end
            end
            FLUSH:   state_d = empty_i ? RUN : DRAIN;
            DRAIN:   if (empty_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= RUN;
            flush_q    <= 1'b0;
            exc_pc_q   <= '0;
            exc_code_q <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= take_fault;
            exc_pc_q   <= exc_pc_d;
            exc_code_q <= exc_code_d;
            wr_en_q    <= wr_en_d;
            retired_q  <= retired_d;
            for (int i = 0; i < RETIRE_COUNT; i++) begin
                wr_addr_q[i] <= slot_data_i[i].dest_reg;
                wr_data_q[i] <= slot_data_i[i].result_lo;
            end
        end
    end

    assign flush_o           = flush_q;
    assign exc_pc_o          = exc_pc_q;
    assign exc_code_o        = exc_code_q;
    assign rfile_wr_enable_o = wr_en_q;
    assign rfile_wr_addr_o   = wr_addr_q;
    assign rfile_wr_data_o   = wr_data_q;
    assign retired_count_o   = retired_q;

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard bench for retire_unit: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_retire_unit;
    import retire_unit_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    rob_entry_t [3:0]     slot_data;
    logic [3:0]           slot_valid;
    logic                 empty;
    logic                 store_ready;
    logic                 consume;
    logic [1:0]           consume_count;
    logic                 store_commit;
    logic                 flush;
    logic [31:0]          exc_pc;
    logic [4:0]           exc_code;
    logic [3:0][4:0]      wr_addr;
    logic [3:0]           wr_en;
    logic [3:0][31:0]     wr_data;
    logic [31:0]          retired_count;

    always #5 clk = ~clk;

    retire_unit #(.RETIRE_COUNT(4), .COUNT_WIDTH(2), .CNT_WIDTH(32)) dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .slot_data_i       (slot_data),
        .slot_valid_i      (slot_valid),
        .empty_i           (empty),
        .consume_o         (consume),
        .consume_count_o   (consume_count),
        .store_ready_i     (store_ready),
        .store_commit_o    (store_commit),
        .flush_o           (flush),
        .exc_pc_o          (exc_pc),
        .exc_code_o        (exc_code),
        .rfile_wr_addr_o   (wr_addr),
        .rfile_wr_enable_o (wr_en),
        .rfile_wr_data_o   (wr_data),
        .retired_count_o   (retired_count)
    );

    typedef struct {
        string            name;
        logic             cons;
        logic [1:0]       cc;
        logic             sc;
        logic             fl;
        logic [31:0]      pc;
        logic [4:0]       code;
        logic [3:0]       wen;
        logic [3:0][4:0]  wa;
        logic [3:0][31:0] wd;
        logic [31:0]      cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [3:0][4:0]  ew_addr;
    logic [3:0][31:0] ew_data;
    int               pass_cnt  = 0;
    int               total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".consume"},       32'(consume),       32'(e.cons));
            check({e.name, ".consume_count"}, 32'(consume_count), 32'(e.cc));
            check({e.name, ".store_commit"},  32'(store_commit),  32'(e.sc));
            check({e.name, ".flush"},         32'(flush),         32'(e.fl));
            check({e.name, ".exc_pc"},        exc_pc,             e.pc);
            check({e.name, ".exc_code"},      32'(exc_code),      32'(e.code));
            check({e.name, ".wr_enable"},     32'(wr_en),         32'(e.wen));
            check({e.name, ".retired_count"}, retired_count,      e.cnt);
            for (int i = 0; i < 4; i++) begin
                if (e.wen[i]) begin
                    check($sformatf("%s.wr_addr%0d", e.name, i), 32'(wr_addr[i]), 32'(e.wa[i]));
                    check($sformatf("%s.wr_data%0d", e.name, i), wr_data[i],      e.wd[i]);
                end
            end
            $display("%s: consume=%0b cc=%0d sc=%0b flush=%0b wr_en=%b cnt=%0d",
                     e.name, consume, consume_count, store_commit, flush, wr_en, retired_count);
        end
    end

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) slot_data[i] = '0;
        slot_valid  = '0;
        store_ready = 1'b1;
    endtask

    task automatic set_slot(input int i, input logic dv, input logic [4:0] d, input logic [31:0] r);
        slot_valid[i]               = 1'b1;
        slot_data[i].dest_reg_valid = dv;
        slot_data[i].dest_reg       = d;
        slot_data[i].result_lo      = r;
        slot_data[i].pc             = 32'h1000 + 32'(i * 4);
    endtask

    task automatic set_wr(input int i, input logic [4:0] a, input logic [31:0] d);
        ew_addr[i] = a;
        ew_data[i] = d;
    endtask

    task automatic expect_cycle(input string nm, input logic cons, input logic [1:0] cc, input logic sc,
                                input logic fl, input logic [31:0] pc, input logic [4:0] code,
                                input logic [3:0] wen, input logic [31:0] cnt);
        exp_t e;
        e.name = nm; e.cons = cons; e.cc = cc; e.sc = sc; e.fl = fl;
        e.pc = pc; e.code = code; e.wen = wen; e.wa = ew_addr; e.wd = ew_data; e.cnt = cnt;
        exp_q.push_back(e);
        ew_addr = '0;
        ew_data = '0;
    endtask

    task automatic fill_plain();
        clear_slots();
        for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; empty = 1'b0; ew_addr = '0; ew_data = '0;
        clear_slots();
        repeat (2) @(posedge clk);
        #1 expect_cycle("reset", 0, 0, 0, 0, 32'h0, 5'd0, 4'b0000, 0);

        @(posedge clk); #1 rst = 1'b0;
        clear_slots();
        set_slot(0, 1, 5'd1, 32'h11); set_slot(1, 1, 5'd2, 32'h22);
        set_slot(2, 1, 5'd3, 32'h33); set_slot(3, 1, 5'd4, 32'h44);
        expect_cycle("all4", 1, 3, 0, 0, 32'h0, 5'd0, 4'b0000, 0);

        @(posedge clk); #1 clear_slots();
        set_slot(0, 1, 5'd6, 32'h66); set_slot(1, 1, 5'd7, 32'h77); set_slot(3, 1, 5'd8, 32'h88);
        set_wr(0, 5'd1, 32'h11); set_wr(1, 5'd2, 32'h22); set_wr(2, 5'd3, 32'h33); set_wr(3, 5'd4, 32'h44);
        expect_cycle("gap", 1, 1, 0, 0, 32'h0, 5'd0, 4'b1111, 4);

        @(posedge clk); #1 clear_slots();
        set_slot(0, 1, 5'd9, 32'h99); set_slot(1, 1, 5'd10, 32'hA0);
        set_slot(2, 1, 5'd11, 32'hB0); set_slot(3, 1, 5'd12, 32'hC0);
        slot_data[2].exc_valid = 1'b1; slot_data[2].pc = 32'h400010; slot_data[2].exc_code = 5'd4;
        set_wr(0, 5'd6, 32'h66); set_wr(1, 5'd7, 32'h77);
        expect_cycle("exc2", 1, 1, 0, 0, 32'h0, 5'd0, 4'b0011, 6);

        @(posedge clk); #1 fill_plain(); empty = 1'b0;
        set_wr(0, 5'd9, 32'h99); set_wr(1, 5'd10, 32'hA0);
        expect_cycle("flush", 0, 0, 0, 1, 32'h400010, 5'd4, 4'b0011, 8);

        @(posedge clk); #1 fill_plain(); empty = 1'b0;
        expect_cycle("drain", 0, 0, 0, 0, 32'h400010, 5'd4, 4'b0000, 8);

        @(posedge clk); #1 clear_slots(); empty = 1'b1;
        expect_cycle("drain_empty", 0, 0, 0, 0, 32'h400010, 5'd4, 4'b0000, 8);

        @(posedge clk); #1 fill_plain(); empty = 1'b0;
        slot_data[1].is_store = 1'b1; slot_data[3].is_store = 1'b1;
        expect_cycle("stores_rdy", 1, 2, 1, 0, 32'h400010, 5'd4, 4'b0000, 8);

        @(posedge clk); #1 store_ready = 1'b0;
        expect_cycle("stores_nrdy", 1, 0, 0, 0, 32'h400010, 5'd4, 4'b0000, 11);

        @(posedge clk); #1 clear_slots();
        set_slot(0, 1, 5'd5, 32'hAAAA); set_slot(1, 1, 5'd0, 32'h1234);
        set_slot(2, 1, 5'd5, 32'hBBBB); set_slot(3, 0, 5'd7, 32'h7777);
        expect_cycle("dup_r5", 1, 3, 0, 0, 32'h400010, 5'd4, 4'b0000, 12);

        @(posedge clk); #1 clear_slots();
        set_slot(0, 1, 5'd12, 32'hC0); set_slot(1, 1, 5'd13, 32'hD0);
        slot_data[1].exc_valid = 1'b1; slot_data[1].pc = 32'h500000; slot_data[1].exc_code = 5'd7;
        set_wr(2, 5'd5, 32'hBBBB);
        expect_cycle("exc1", 1, 0, 0, 0, 32'h400010, 5'd4, 4'b0100, 16);

        @(posedge clk); #1 fill_plain(); empty = 1'b0;
        set_wr(0, 5'd12, 32'hC0);
        expect_cycle("flush2", 0, 0, 0, 1, 32'h500000, 5'd7, 4'b0001, 17);

        // Reset lands in the middle of the FLUSH cycle.
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check("async_rst.flush",         32'(flush),   32'h0);
        check("async_rst.wr_enable",     32'(wr_en),   32'h0);
        check("async_rst.retired_count", retired_count, 32'h0);
        check("async_rst.exc_pc",        exc_pc,        32'h0);
        $display("async_rst: flush=%0b wr_en=%b cnt=%0d", flush, wr_en, retired_count);

        @(posedge clk); #1 rst = 1'b0;
        clear_slots();
        set_slot(0, 1, 5'd1, 32'h51); set_slot(1, 1, 5'd2, 32'h52);
        set_slot(2, 1, 5'd3, 32'h53); set_slot(3, 1, 5'd4, 32'h54);
        expect_cycle("post_rst", 1, 3, 0, 0, 32'h0, 5'd0, 4'b0000, 0);

        @(posedge clk); #1 clear_slots();
        set_wr(0, 5'd1, 32'h51); set_wr(1, 5'd2, 32'h52); set_wr(2, 5'd3, 32'h53); set_wr(3, 5'd4, 32'h54);
        expect_cycle("post_rst_wr", 0, 0, 0, 0, 32'h0, 5'd0, 4'b1111, 4);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
